// File: rtl/box_datapath_if.sv
// Control and pixel bus between the box-drawing FSM and its datapath.
// The FSM side drives the enables and switch values. The datapath side returns the counter and the registered VGA pixel signals.
interface box_datapath_if;
    logic [6:0]  DataIn;
    logic [2:0]  ColorIn;
    logic        enRegX;
    logic        enRegY;
    logic        enColor;
    logic        enCount;
    logic        enALU;
    logic        Plot;
    logic        SelectPath;
    logic        enBlackCount;
    logic [14:0] counter;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn;

    modport master (
        output DataIn, ColorIn, enRegX, enRegY, enColor, enCount,
               enALU, Plot, SelectPath, enBlackCount,
        input  counter, x, y, colour, writeEn
    );

    modport slave (
        input  DataIn, ColorIn, enRegX, enRegY, enColor, enCount,
               enALU, Plot, SelectPath, enBlackCount,
        output counter, x, y, colour, writeEn
    );
endinterface

// File: rtl/box_datapath.sv
// Box/clear-screen datapath: X/Y/C registers, 4x4 box offset counter, full-screen clear sweep.
// Latency: pixel outputs registered, 1 cycle after select; counter is combinational from its register.
// Backpressure: none; the FSM paces every step by its enables and the VGA adapter always accepts.
module box_datapath #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic          Clock,
    input  logic          Reset,
    box_datapath_if.slave bus
);
    localparam logic [7:0] BX_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] BY_LAST = 7'(SCREEN_H - 1);

    logic [7:0]  x_reg;
    logic [6:0]  y_reg;
    logic [2:0]  c_reg;
    logic [14:0] count;
    logic [7:0]  bx;
    logic [6:0]  by;

    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour_out;
    logic        write_out;

    logic [6:0]  y_base;
    logic [7:0]  xn;
    logic [6:0]  yn;
    logic [2:0]  cn;
    logic        wn;
    logic        sweep_last;
    logic        row_last;

    assign row_last   = (bx == BX_LAST);
    assign sweep_last = row_last && (by == BY_LAST);

    // The load-Y state also draws, so the freshly switched-in row must be used before Y is written.
    assign y_base = bus.enRegY ? bus.DataIn : y_reg;

    always_comb begin
        xn = bx;
        yn = by;
        cn = 3'd0;
        wn = bus.enBlackCount;
        if (bus.SelectPath) begin
            wn = bus.Plot;
            cn = c_reg;
            if (bus.enALU) begin
                xn = x_reg + {6'd0, count[1:0]};
                yn = y_base + {5'd0, count[3:2]};
            end else begin
                xn = x_reg;
                yn = y_reg;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            x_reg      <= '0;
            y_reg      <= '0;
            c_reg      <= '0;
            count      <= '0;
            bx         <= '0;
            by         <= '0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            write_out  <= 1'b0;
        end else begin
            if (bus.enRegX)  x_reg <= {1'b0, bus.DataIn};
            if (bus.enRegY)  y_reg <= bus.DataIn;
            if (bus.enColor) c_reg <= bus.ColorIn;

            // The clear sweep owns the shared counter whenever it runs.
            if (bus.enBlackCount) begin
                if (sweep_last) begin
                    bx    <= '0;
                    by    <= '0;
                    count <= '0;
                end else begin
                    count <= count + 15'd1;
                    if (row_last) begin
                        bx <= '0;
                        by <= by + 7'd1;
                    end else begin
                        bx <= bx + 8'd1;
                    end
                end
            end else if (bus.enCount) begin
                count <= {11'd0, count[3:0] + 4'd1};
            end

            x_out      <= xn;
            y_out      <= yn;
            colour_out <= cn;
            write_out  <= wn;
        end
    end

    assign bus.counter = count;
    assign bus.x       = x_out;
    assign bus.y       = y_out;
    assign bus.colour  = colour_out;
    assign bus.writeEn = write_out;
endmodule

// File: tb/tb_box_datapath.sv
// Bench for box_datapath: expected pixels are queued as stimulus is driven and checked as writes appear.
// Inputs change 1 time unit after the rising edge, and writes are sampled on the falling edge.
module tb_box_datapath;
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic Clock = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    int   writes   = 0;
    bit   mon_en   = 1'b0;
    pix_t exp_q[$];

    box_datapath_if bus ();

    box_datapath #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Scoreboard: every observed write must match the oldest queued pixel.
    always @(negedge Clock) begin
        if (mon_en && bus.writeEn === 1'b1) begin
            pix_t got, want;
            got = '{x: bus.x, y: bus.y, c: bus.colour};
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got x=%0d y=%0d c=%0d, required no write", got.x, got.y, got.c);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL pixel got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                             got.x, got.y, got.c, want.x, want.y, want.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.enRegX = 0; bus.enRegY = 0; bus.enColor = 0; bus.enCount = 0;
        bus.enALU = 0; bus.Plot = 0; bus.enBlackCount = 0;
    endtask

    task automatic test_reset();
        idle();
        bus.SelectPath = 1; bus.DataIn = 0; bus.ColorIn = 0;
        Reset = 1;
        tick();
        // Second reset cycle with random enables; Reset must win.
        {bus.enRegX, bus.enRegY, bus.enColor, bus.enCount, bus.enALU,
         bus.Plot, bus.SelectPath, bus.enBlackCount} = 8'($urandom);
        bus.DataIn = 7'($urandom); bus.ColorIn = 3'($urandom);
        tick();
        Reset = 0;
        idle();
        bus.SelectPath = 1;
        checks++; if (bus.counter !== 15'd0) begin failures++; $display("FAIL reset_counter got %0d required 0", bus.counter); end
        checks++; if (bus.x !== 8'd0)        begin failures++; $display("FAIL reset_x got %0d required 0", bus.x); end
        checks++; if (bus.y !== 7'd0)        begin failures++; $display("FAIL reset_y got %0d required 0", bus.y); end
        checks++; if (bus.colour !== 3'd0)   begin failures++; $display("FAIL reset_colour got %0d required 0", bus.colour); end
        checks++; if (bus.writeEn !== 1'b0)  begin failures++; $display("FAIL reset_writeEn got %0d required 0", bus.writeEn); end
        mon_en = 1'b1;
    endtask

    // Full FSM-style box: load X/C, load Y with first draw, then 16 offset draws.
    task automatic test_box(input logic [7:0] xv, input logic [6:0] yv, input logic [2:0] cv, input string name);
        int w0;
        logic [3:0] c4;
        w0 = writes;
        idle();
        bus.SelectPath = 1;
        bus.DataIn = xv[6:0]; bus.ColorIn = cv; bus.enRegX = 1; bus.enColor = 1;
        tick();
        idle();
        bus.DataIn = yv; bus.enRegY = 1; bus.enALU = 1; bus.Plot = 1;
        checks++; if (bus.counter !== 15'd0) begin failures++; $display("FAIL %s_start_counter got %0d required 0", name, bus.counter); end
        exp_q.push_back('{x: xv, y: yv, c: cv});
        tick();
        idle();
        bus.DataIn = 7'd0;
        for (int c = 0; c < 16; c++) begin
            c4 = 4'(c);
            bus.enCount = 1; bus.enALU = 1; bus.Plot = 1;
            if (c == 5 || c == 15) begin
                checks++;
                if (bus.counter !== 15'(c)) begin failures++; $display("FAIL %s_counter got %0d required %0d", name, bus.counter, c); end
            end
            exp_q.push_back('{x: xv + 8'(c4[1:0]), y: 7'(yv + 7'(c4[3:2])), c: cv});
            tick();
        end
        idle();
        checks++; if (bus.counter !== 15'd0) begin failures++; $display("FAIL %s_wrap_counter got %0d required 0", name, bus.counter); end
        tick();
        tick();
        checks++; if (writes - w0 !== 17) begin failures++; $display("FAIL %s_write_count got %0d required 17", name, writes - w0); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL %s_pending got %0d required 0", name, exp_q.size()); end
    endtask

    task automatic test_y_bypass();
        idle();
        bus.SelectPath = 1; bus.DataIn = 7'd7; bus.enRegY = 1;
        tick();
        idle();
        test_box(8'd30, 7'd50, 3'b010, "ybypass");
    endtask

    // Runs n sweep cycles starting from sweep index 0, queuing each pixel.
    task automatic sweep(input int n, input string name);
        idle();
        bus.SelectPath = 0;
        for (int k = 0; k < n; k++) begin
            bus.enBlackCount = 1;
            if (k == 0 || k == 159 || k == 160 || k == 5000 || k == 19199) begin
                checks++;
                if (bus.counter !== 15'(k)) begin failures++; $display("FAIL %s_counter got %0d required %0d", name, bus.counter, k); end
            end
            exp_q.push_back('{x: 8'(k % 160), y: 7'(k / 160), c: 3'd0});
            tick();
        end
    endtask

    task automatic test_clear();
        int w0;
        w0 = writes;
        sweep(19200, "clear");
        idle();
        checks++; if (bus.counter !== 15'd0) begin failures++; $display("FAIL clear_end_counter got %0d required 0", bus.counter); end
        checks++; if (bus.writeEn !== 1'b1)  begin failures++; $display("FAIL clear_last_writeEn got %0d required 1", bus.writeEn); end
        tick();
        checks++; if (bus.writeEn !== 1'b0)  begin failures++; $display("FAIL clear_fall_writeEn got %0d required 0", bus.writeEn); end
        tick();
        checks++; if (writes - w0 !== 19200) begin failures++; $display("FAIL clear_write_count got %0d required 19200", writes - w0); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL clear_pending got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_mid_sweep_reset();
        sweep(5000, "midsweep");
        checks++; if (bus.counter !== 15'd5000) begin failures++; $display("FAIL midsweep_at_reset got %0d required 5000", bus.counter); end
        Reset = 1;
        tick();
        Reset = 0;
        idle();
        checks++; if (bus.counter !== 15'd0) begin failures++; $display("FAIL midsweep_after_reset got %0d required 0", bus.counter); end
        checks++; if (bus.writeEn !== 1'b0)  begin failures++; $display("FAIL midsweep_reset_writeEn got %0d required 0", bus.writeEn); end
        sweep(200, "restart");
        idle();
        tick();
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL restart_pending got %0d required 0", exp_q.size()); end
    endtask

    initial begin
        Reset = 1;
        test_reset();
        test_box(8'd10, 7'd20, 3'b101, "box");
        test_y_bypass();
        test_box(8'd127, 7'd126, 3'b011, "rowwrap");
        test_clear();
        test_mid_sweep_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
